// File: rtl/wb_stage.sv
// RV32I writeback: registers the MEM result (with load formatting) or an MDU result from a small FIFO; 1-cycle latency.
// MDU input backpressure via mdu_ready (!full); a starved MDU head forces priority and stalls MEM through wb_hold_req.
module wb_stage #(
  parameter int MDU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_dst,
  input  logic [31:0] mdu_result,
  output logic        mdu_ready,
  output logic        wb_hold_req,
  output logic        regwrite_wb,
  output logic [4:0]  dst_wb,
  output logic [31:0] regwd_wb,
  output logic        wb_src
);

  localparam int PW = $clog2(MDU_DEPTH);
  localparam int CW = $clog2(MDU_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] dat;
  } mdu_ent_t;

  mdu_ent_t      fifo_q [MDU_DEPTH];
  mdu_ent_t      fifo_d [MDU_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    dst_q, dst_d;
  logic [31:0]   regwd_q, regwd_d;
  logic          src_q, src_d;

  logic          pipe_req;
  logic          fifo_ne;
  logic          fifo_full;
  logic          force_mdu;
  logic          push;
  logic          pop;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   pipe_data;

  always_comb begin
    ld_byte = mem_rdata[{mem_alu_result[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{mem_alu_result[1], 4'b0000} +: 16];
    case (mem_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
    pipe_data = mem_memtoreg ? ld_data : mem_alu_result;
  end

  assign pipe_req    = mem_valid & mem_regwrite & (mem_dst != 5'd0);
  assign fifo_ne     = (count_q != '0);
  assign fifo_full   = (count_q == CW'(MDU_DEPTH));
  // Readiness comes from the registered count only, so a same-cycle pop never opens a slot.
  assign mdu_ready   = ~rst & ~fifo_full;
  assign push        = mdu_valid & mdu_ready & (mdu_dst != 5'd0);
  assign force_mdu   = fifo_ne & (starve_q == SW'(STARVE_LIMIT));
  assign pop         = force_mdu | (fifo_ne & ~pipe_req);
  assign wb_hold_req = force_mdu & ~rst;

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = '0;
    regwrite_d = 1'b0;
    dst_d      = dst_q;
    regwd_d    = regwd_q;
    src_d      = src_q;

    if (pop) begin
      regwrite_d = 1'b1;
      dst_d      = fifo_q[rd_ptr_q].dst;
      regwd_d    = fifo_q[rd_ptr_q].dat;
      src_d      = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end else if (pipe_req) begin
      regwrite_d = 1'b1;
      dst_d      = mem_dst;
      regwd_d    = pipe_data;
      src_d      = 1'b0;
      if (fifo_ne) begin
        starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{dst: mdu_dst, dat: mdu_result};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      dst_q      <= '0;
      regwd_q    <= '0;
      src_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      dst_q      <= dst_d;
      regwd_q    <= regwd_d;
      src_q      <= src_d;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign regwrite_wb = regwrite_q;
  assign dst_wb      = dst_q;
  assign regwd_wb    = regwd_q;
  assign wb_src      = src_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_regwrite, mem_memtoreg;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_dst;
  logic [31:0] mem_alu_result, mem_rdata;
  logic        mdu_valid;
  logic [4:0]  mdu_dst;
  logic [31:0] mdu_result;
  logic        mdu_ready, wb_hold_req, regwrite_wb, wb_src;
  logic [4:0]  dst_wb;
  logic [31:0] regwd_wb;

  always #5 clk = ~clk;

  wb_stage #(.MDU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_funct3(mem_funct3), .mem_dst(mem_dst), .mem_alu_result(mem_alu_result),
    .mem_rdata(mem_rdata), .mdu_valid(mdu_valid), .mdu_dst(mdu_dst), .mdu_result(mdu_result),
    .mdu_ready(mdu_ready), .wb_hold_req(wb_hold_req), .regwrite_wb(regwrite_wb),
    .dst_wb(dst_wb), .regwd_wb(regwd_wb), .wb_src(wb_src)
  );

  typedef struct packed {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        q[$];
  int          starve;
  logic        e_rw, e_src;
  logic [4:0]  e_dst;
  logic [31:0] e_wd;
  logic        last_hold, last_acc;
  logic        obs_ready, obs_hold;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off, b, h;
    off = addr % 4;
    b   = (rd >> (8 * off)) % 256;
    h   = (rd >> (16 * (off / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32768) ? h - 32'h10000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check the registered outputs after the edge.
  task automatic cycle();
    logic m_ready, frc, req;
    ent_t e;
    #1;
    m_ready   = !rst && (q.size() < DEPTH);
    frc       = (q.size() != 0) && (starve == LIMIT);
    obs_ready = mdu_ready;
    obs_hold  = wb_hold_req;
    chk("mdu_ready", mdu_ready, m_ready);
    if (!rst) chk("wb_hold_req", wb_hold_req, frc);
    last_hold = frc && !rst;
    last_acc  = mdu_valid && m_ready;
    if (rst) begin
      q.delete();
      starve = 0;
      e_rw = 0; e_dst = 0; e_wd = 0; e_src = 0;
    end else begin
      req = mem_valid && mem_regwrite && (mem_dst != 0);
      if (frc || (!req && q.size() != 0)) begin
        e = q.pop_front();
        e_rw = 1; e_dst = e.d; e_wd = e.v; e_src = 1;
        starve = 0;
      end else if (req) begin
        e_rw = 1; e_dst = mem_dst; e_src = 0;
        e_wd = mem_memtoreg ? load_fmt(mem_funct3, mem_alu_result, mem_rdata) : mem_alu_result;
        starve = (q.size() != 0) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      end else begin
        e_rw = 0;
        starve = 0;
      end
      if (last_acc && mdu_dst != 0) q.push_back('{d: mdu_dst, v: mdu_result});
    end
    @(posedge clk);
    #1;
    chk("regwrite_wb", regwrite_wb, e_rw);
    chk("dst_wb", dst_wb, e_dst);
    chk("regwd_wb", regwd_wb, e_wd);
    chk("wb_src", wb_src, e_src);
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0; mem_funct3 = 0; mem_dst = 0;
    mem_alu_result = 0; mem_rdata = 0; mdu_valid = 0; mdu_dst = 0; mdu_result = 0;
  endtask

  task automatic pipe_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] d);
    mem_valid = 1; mem_regwrite = 1; mem_memtoreg = 1; mem_funct3 = f3;
    mem_alu_result = addr; mem_rdata = 32'h80FF1234; mem_dst = d;
  endtask

  initial begin
    logic [31:0] rs [3];
    int idx;
    rs[0] = 32'hA0000001; rs[1] = 32'hA0000002; rs[2] = 32'hA0000003;
    starve = 0; e_rw = 0; e_dst = 0; e_wd = 0; e_src = 0;
    last_hold = 0; last_acc = 0;
    idle_inputs();
    rst = 1;
    cycle(); cycle();
    chk("rst_regwrite", regwrite_wb, 0);
    chk("rst_dst", dst_wb, 0);
    chk("rst_wd", regwd_wb, 0);
    chk("rst_ready", obs_ready, 0);
    rst = 0;

    pipe_load(3'b000, 32'h00001003, 5'd5); cycle();
    chk("lb_rw", regwrite_wb, 1); chk("lb_dst", dst_wb, 5); chk("lb_wd", regwd_wb, 32'hFFFFFF80);
    pipe_load(3'b100, 32'h00001003, 5'd5); cycle();
    chk("lbu_wd", regwd_wb, 32'h00000080);
    pipe_load(3'b101, 32'h00001002, 5'd6); cycle();
    chk("lhu_wd", regwd_wb, 32'h000080FF);
    pipe_load(3'b001, 32'h00001000, 5'd6); cycle();
    chk("lh_wd", regwd_wb, 32'h00001234);
    pipe_load(3'b010, 32'hDEADBEEF, 5'd8); mem_memtoreg = 0; cycle();
    chk("alu_wd", regwd_wb, 32'hDEADBEEF);
    mem_dst = 0; cycle();
    chk("dst0_rw", regwrite_wb, 0);
    mem_dst = 8; mem_valid = 0; cycle();
    chk("novalid_rw", regwrite_wb, 0);

    idle_inputs(); mdu_valid = 1; mdu_dst = 0; mdu_result = 32'h55555555; cycle();
    chk("mdu_dst0_acc", obs_ready, 1);
    idle_inputs(); cycle(); cycle();
    chk("mdu_dst0_rw", regwrite_wb, 0);

    mdu_valid = 1; mdu_dst = 7; mdu_result = 32'h12345678; cycle();
    idle_inputs(); cycle();
    chk("mdu_rw", regwrite_wb, 1); chk("mdu_dst", dst_wb, 7);
    chk("mdu_wd", regwd_wb, 32'h12345678); chk("mdu_src", wb_src, 1);
    cycle();
    chk("mdu_empty_rw", regwrite_wb, 0);

    // Pipe writes every cycle while three MDU results compete for the port.
    mem_valid = 1; mem_regwrite = 1; mem_memtoreg = 0; mem_dst = 3;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (!last_hold) mem_alu_result = 32'h30000000 + c;
      mdu_valid = (idx < 3); mdu_dst = 5'(9 + idx); mdu_result = rs[idx % 3];
      cycle();
      if (c == 2) chk("ready_full", obs_ready, 0);
      if (c == 4) chk("no_hold_yet", obs_hold, 0);
      if (c == 5) begin
        chk("starve_hold", obs_hold, 1);
        chk("force_src", wb_src, 1);
        chk("force_wd", regwd_wb, rs[0]);
      end
      if (c == 6) begin
        chk("stalled_src", wb_src, 0);
        chk("stalled_wd", regwd_wb, 32'h30000005);
      end
      if (last_acc) idx++;
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) cycle();

    // Reset while the FIFO holds two entries.
    mem_valid = 1; mem_regwrite = 1; mem_dst = 4; mem_alu_result = 32'h44444444;
    mdu_valid = 1; mdu_dst = 10; mdu_result = 32'hBBBB0001; cycle();
    mdu_dst = 11; mdu_result = 32'hBBBB0002; cycle();
    rst = 1; cycle();
    chk("mrst_rw", regwrite_wb, 0); chk("mrst_wd", regwd_wb, 0);
    chk("mrst_dst", dst_wb, 0); chk("mrst_ready", obs_ready, 0);
    rst = 0; idle_inputs();
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("post_rst_rw", regwrite_wb, 0);
      chk("post_rst_ready", obs_ready, 1);
    end

    // Randomized traffic; MEM inputs honour wb_hold_req and MDU keeps valid until accepted.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!last_hold) begin
        mem_valid      = ($urandom_range(0, 9) < 7);
        mem_regwrite   = ($urandom_range(0, 9) < 8);
        mem_memtoreg   = $urandom_range(0, 1);
        mem_funct3     = 3'($urandom_range(0, 7));
        mem_dst        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem_alu_result = $urandom;
        mem_rdata      = $urandom;
      end
      if (!(mdu_valid && !last_acc)) begin
        mdu_valid  = ($urandom_range(0, 9) < 4);
        mdu_dst    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mdu_result = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
